// File: rtl/ex_hazard_ctrl.sv
// Execute-stage pipeline sequencer: load-use stall, branch flush, multi-cycle
// hold of EX, and saturating stall/flush cycle counters.
module ex_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_LAT       = 4,
  parameter int RA_W         = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            de_valid,
  input  logic [RA_W-1:0] de_rs1,
  input  logic [RA_W-1:0] de_rs2,
  input  logic            de_uses_rs1,
  input  logic            de_uses_rs2,
  input  logic            de_multicycle,
  input  logic            ex_valid,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_mem_read,
  input  logic            branch_taken,
  output logic            stall_fd,
  output logic            bubble_ex,
  output logic            flush_fd,
  output logic            ex_busy,
  output logic            mc_done,
  output logic [1:0]      ctrl_state,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
);

  localparam int CNT_MAX = (FLUSH_CYCLES > MC_LAT) ? FLUSH_CYCLES : MC_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  // Counter preloads: the first FLUSH/MC_BUSY cycle already counts as one.
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((FLUSH_CYCLES >= 2) ? (FLUSH_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0] MC_LOAD    = CNT_W'(MC_LAT - 2);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MC_BUSY = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  state_e           state_r;
  state_e           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;
  logic             mc_done_r;
  logic             mc_fire_s;
  logic [31:0]      perf_stall_cnt_r;
  logic [31:0]      perf_flush_cnt_r;
  logic             lu_s;
  logic             stall_s;
  logic             bubble_s;
  logic             flush_s;
  logic             busy_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  // Load-use hazard: a load in EX writes a register the decode instruction reads.
  always_comb begin
    lu_s = ex_valid & ex_mem_read & (ex_rd != {RA_W{1'b0}}) & de_valid &
           ((de_uses_rs1 & (de_rs1 == ex_rd)) | (de_uses_rs2 & (de_rs2 == ex_rd)));
  end

  // Next-state, counter and raw control decode.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    stall_s      = 1'b0;
    bubble_s     = 1'b0;
    flush_s      = 1'b0;
    busy_s       = 1'b0;
    mc_fire_s    = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (branch_taken) begin
          flush_s  = 1'b1;
          bubble_s = 1'b1;
          if (FLUSH_CYCLES == 1) begin
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_FLUSH;
            next_cnt_s   = FLUSH_LOAD;
          end
        end else if (lu_s) begin
          // Single-cycle hold: the inserted bubble clears the hazard next cycle.
          stall_s      = 1'b1;
          bubble_s     = 1'b1;
          next_state_s = ST_RUN;
        end else if (de_valid && de_multicycle) begin
          // The op moves into EX this cycle, so no hold yet.
          next_state_s = ST_MC_BUSY;
          next_cnt_s   = MC_LOAD;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // EX holds a bubble here, so a branch indication cannot be real.
        flush_s  = 1'b1;
        bubble_s = 1'b1;
        if (cnt_r == {CNT_W{1'b0}}) begin
          next_state_s = ST_RUN;
        end else begin
          next_cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_MC_BUSY: begin
        stall_s = 1'b1;
        busy_s  = 1'b1;
        if (cnt_r == {CNT_W{1'b0}}) begin
          next_state_s = ST_RUN;
          mc_fire_s    = 1'b1;
        end else begin
          next_cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        next_state_s = ST_RUN;
        next_cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Control outputs are forced low while reset is asserted.
  always_comb begin
    stall_fd  = rst_n & stall_s;
    bubble_ex = rst_n & bubble_s;
    flush_fd  = rst_n & flush_s;
    ex_busy   = rst_n & busy_s;
  end

  // State, down-counter and completion pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      cnt_r     <= {CNT_W{1'b0}};
      mc_done_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= next_cnt_s;
      mc_done_r <= mc_fire_s;
    end
  end

  // Saturating performance counters of stall and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_r <= 32'd0;
      perf_flush_cnt_r <= 32'd0;
    end else begin
      if (stall_fd) begin
        perf_stall_cnt_r <= sat_inc(perf_stall_cnt_r);
      end else begin
        perf_stall_cnt_r <= perf_stall_cnt_r;
      end
      if (flush_fd) begin
        perf_flush_cnt_r <= sat_inc(perf_flush_cnt_r);
      end else begin
        perf_flush_cnt_r <= perf_flush_cnt_r;
      end
    end
  end

  assign ctrl_state     = state_r;
  assign mc_done        = mc_done_r;
  assign perf_stall_cnt = perf_stall_cnt_r;
  assign perf_flush_cnt = perf_flush_cnt_r;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios plus random traffic, all
// checked against a remaining-cycles reference model.
module tb_ex_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int MC_LAT       = 4;
  localparam int RA_W         = 5;

  logic            clk;
  logic            rst_n;
  logic            de_valid;
  logic [RA_W-1:0] de_rs1;
  logic [RA_W-1:0] de_rs2;
  logic            de_uses_rs1;
  logic            de_uses_rs2;
  logic            de_multicycle;
  logic            ex_valid;
  logic [RA_W-1:0] ex_rd;
  logic            ex_mem_read;
  logic            branch_taken;
  logic            stall_fd;
  logic            bubble_ex;
  logic            flush_fd;
  logic            ex_busy;
  logic            mc_done;
  logic [1:0]      ctrl_state;
  logic [31:0]     perf_stall_cnt;
  logic [31:0]     perf_flush_cnt;

  int tests_run;
  int tests_failed;

  // Reference model: remaining cycles of each activity, pending done pulse, counts.
  int          m_flush_rem;
  int          m_mc_rem;
  bit          m_done;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_flush_cnt;

  ex_hazard_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .MC_LAT      (MC_LAT),
    .RA_W        (RA_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .de_valid      (de_valid),
    .de_rs1        (de_rs1),
    .de_rs2        (de_rs2),
    .de_uses_rs1   (de_uses_rs1),
    .de_uses_rs2   (de_uses_rs2),
    .de_multicycle (de_multicycle),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .branch_taken  (branch_taken),
    .stall_fd      (stall_fd),
    .bubble_ex     (bubble_ex),
    .flush_fd      (flush_fd),
    .ex_busy       (ex_busy),
    .mc_done       (mc_done),
    .ctrl_state    (ctrl_state),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush_rem = 0;
    m_mc_rem    = 0;
    m_done      = 1'b0;
    m_stall_cnt = 32'd0;
    m_flush_cnt = 32'd0;
  endtask

  task automatic set_idle();
    de_valid = 1'b0; de_rs1 = '0; de_rs2 = '0; de_uses_rs1 = 1'b0; de_uses_rs2 = 1'b0;
    de_multicycle = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_mem_read = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic randomize_inputs();
    de_valid      = ($urandom_range(0, 3) != 0);
    de_rs1        = RA_W'($urandom_range(0, 3));
    de_rs2        = RA_W'($urandom_range(0, 3));
    de_uses_rs1   = $urandom_range(0, 1) == 1;
    de_uses_rs2   = $urandom_range(0, 1) == 1;
    de_multicycle = ($urandom_range(0, 99) < 15);
    ex_valid      = $urandom_range(0, 1) == 1;
    ex_rd         = RA_W'($urandom_range(0, 3));
    ex_mem_read   = $urandom_range(0, 1) == 1;
    branch_taken  = ($urandom_range(0, 99) < 10);
  endtask

  // One clock cycle: inputs already driven; compare, clock, advance the model.
  task automatic cycle();
    bit lu, e_stall, e_bub, e_fl, e_busy;
    int e_state;
    #1;
    lu = ex_valid && ex_mem_read && (ex_rd != 0) && de_valid &&
         ((de_uses_rs1 && de_rs1 == ex_rd) || (de_uses_rs2 && de_rs2 == ex_rd));
    e_stall = 0; e_bub = 0; e_fl = 0; e_busy = 0; e_state = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_mc_rem > 0) begin
      e_stall = 1; e_busy = 1; e_state = 2;
    end else if (m_flush_rem > 0) begin
      e_fl = 1; e_bub = 1; e_state = 1;
    end else if (branch_taken) begin
      e_fl = 1; e_bub = 1;
    end else if (lu) begin
      e_stall = 1; e_bub = 1;
    end
    check_eq("stall_fd",   {31'd0, stall_fd},   {31'd0, e_stall});
    check_eq("bubble_ex",  {31'd0, bubble_ex},  {31'd0, e_bub});
    check_eq("flush_fd",   {31'd0, flush_fd},   {31'd0, e_fl});
    check_eq("ex_busy",    {31'd0, ex_busy},    {31'd0, e_busy});
    check_eq("mc_done",    {31'd0, mc_done},    {31'd0, m_done});
    check_eq("ctrl_state", {30'd0, ctrl_state}, 32'(e_state));
    check_eq("perf_stall", perf_stall_cnt, m_stall_cnt);
    check_eq("perf_flush", perf_flush_cnt, m_flush_cnt);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      if (m_mc_rem > 0) begin
        m_mc_rem--;
        if (m_mc_rem == 0) m_done = 1'b1;
      end else if (m_flush_rem > 0) begin
        m_flush_rem--;
      end else if (branch_taken) begin
        m_flush_rem = FLUSH_CYCLES - 1;
      end else if (!lu && de_valid && de_multicycle) begin
        m_mc_rem = MC_LAT - 1;
      end
      if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 32'd1;
      if (e_fl && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt = m_flush_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    set_idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_reset();
    set_idle();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;

    // Reset held with random inputs: everything must stay quiet.
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      cycle();
    end
    set_idle();
    rst_n = 1'b1;
    cycle();

    // Load-use on rs2, then the bubble cycle, then ex_rd = x0 (no hazard).
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
    de_valid = 1'b1; de_rs2 = 5'd5; de_uses_rs2 = 1'b1;
    cycle();
    check_eq("lu_stall_pulse", perf_stall_cnt, 32'd1);
    ex_valid = 1'b0;
    cycle();
    ex_valid = 1'b1; ex_rd = 5'd0; de_rs2 = 5'd0;
    cycle();
    check_eq("lu_x0_no_stall", perf_stall_cnt, 32'd1);

    // Branch: two flush cycles; a second branch inside FLUSH is ignored.
    reset_pulse();
    set_idle();
    branch_taken = 1'b1;
    cycle();
    cycle();
    branch_taken = 1'b0;
    cycle();
    cycle();
    check_eq("branch_flush_cnt", perf_flush_cnt, 32'd2);

    // Multi-cycle op: hold for MC_LAT-1 cycles, done pulse afterwards.
    reset_pulse();
    de_valid = 1'b1; de_multicycle = 1'b1;
    cycle();
    de_multicycle = 1'b0;
    for (int i = 0; i < MC_LAT; i++) cycle();
    check_eq("mc_stall_cnt", perf_stall_cnt, 32'(MC_LAT - 1));

    // Branch wins over a simultaneous load-use.
    reset_pulse();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
    de_valid = 1'b1; de_rs1 = 5'd3; de_uses_rs1 = 1'b1; branch_taken = 1'b1;
    cycle();
    set_idle();
    cycle();
    check_eq("prio_no_stall", perf_stall_cnt, 32'd0);

    // Reset during MC_BUSY abandons the op: no done pulse afterwards.
    de_valid = 1'b1; de_multicycle = 1'b1;
    cycle();
    set_idle();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < MC_LAT; i++) cycle();

    // Saturation of the stall counter.
    force dut.perf_stall_cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.perf_stall_cnt_r;
    m_stall_cnt = 32'hFFFF_FFFE;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7;
    de_valid = 1'b1; de_rs1 = 5'd7; de_uses_rs1 = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    set_idle();
    cycle();
    check_eq("stall_saturate", perf_stall_cnt, 32'hFFFF_FFFF);

    // Random traffic with occasional asynchronous resets.
    reset_pulse();
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      rst_n = ($urandom_range(0, 99) >= 3);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
